serializer_arbiter: RTL and testbench

SERIALIZER_ARBITER -- requirements
Module: serializer_arbiter

---
 rtl/serializer_arbiter.sv | 109 ++++++++++
 tb/tb_serializer_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that pops one word from a selected source FIFO, loads it
// into an external shift register and streams it out in BEATS link beats.
module serializer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 4,
  localparam int BEATS = INPUT_SIZE / OUTPUT_SIZE,
  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] fifo_data,
  output logic [NUM_REQ-1:0]            read_fifo,
  output logic [INPUT_SIZE-1:0]         sr_data,
  output logic                          sr_load,
  output logic                          sr_shift,
  input  logic                          link_ready,
  output logic                          link_valid,
  output logic [GW-1:0]                 grant_id,
  output logic                          serializer_idle
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] arb_idx;
  logic [GW-1:0] arb_next;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          last_beat;
  logic          pop_ok;

  // Descending scan so the source closest to rr_ptr is written last and wins.
  always_comb begin
    arb_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (!fifo_empty[(int'(rr_ptr) + k) % NUM_REQ])
        arb_idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  assign arb_next  = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
  assign any_req   = ~&fifo_empty;
  assign last_beat = (state == SHIFT) && link_ready && (cnt == CW'(BEATS - 1));
  // The pop is qualified by the live empty flag so a source that drained after
  // being granted is never popped; the FSM then falls back to IDLE.
  assign pop_ok    = (state == POP) && !fifo_empty[grant_id];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= arb_idx;
            rr_ptr   <= arb_next;
            state    <= POP;
          end
        end
        POP:  state <= pop_ok ? LOAD : IDLE;
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (last_beat) begin
            cnt <= '0;
            if (any_req) begin
              grant_id <= arb_idx;
              rr_ptr   <= arb_next;
              state    <= POP;
            end else begin
              state <= IDLE;
            end
          end else if (link_ready) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pop
    assign read_fifo[i] = pop_ok && (grant_id == GW'(i));
  end

  always_comb begin
    sr_data = '0;
    if (state == LOAD)
      sr_data = fifo_data[int'(grant_id) * INPUT_SIZE +: INPUT_SIZE];
  end

  assign sr_load         = (state == LOAD);
  assign link_valid      = (state == SHIFT);
  assign sr_shift        = link_valid & link_ready;
  assign serializer_idle = (state == IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: a per-cycle vector table, directed corner
// sequences, and a randomized run against a transaction-level source/link model.
module tb_serializer_arbiter;
  localparam int NR = 4;
  localparam int IW = 32;
  localparam int BEATS = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   fifo_empty;
  logic [NR*IW-1:0] fifo_data;
  logic [NR-1:0]   read_fifo;
  logic [IW-1:0]   sr_data;
  logic            sr_load, sr_shift, link_ready, link_valid, serializer_idle;
  logic [1:0]      grant_id;

  int total = 0;
  int bad   = 0;

  serializer_arbiter #(.NUM_REQ(NR), .INPUT_SIZE(IW), .OUTPUT_SIZE(4)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .read_fifo(read_fifo), .sr_data(sr_data), .sr_load(sr_load), .sr_shift(sr_shift),
    .link_ready(link_ready), .link_valid(link_valid), .grant_id(grant_id),
    .serializer_idle(serializer_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  fe;
    logic        lr;
    logic [3:0]  rd;
    logic        ld;
    logic        lv;
    logic        sh;
    logic        idle;
    logic [1:0]  gid;
    logic [31:0] data;
  } vec_t;

  vec_t tv[12];
  logic [31:0] q[NR][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] fe, input logic lr);
    @(posedge clk);
    #2;
    fifo_empty = fe;
    link_ready = lr;
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_rd"},   read_fifo, 0);
    chk({tag, "_ld"},   sr_load, 0);
    chk({tag, "_sh"},   sr_shift, 0);
    chk({tag, "_lv"},   link_valid, 0);
    chk({tag, "_data"}, sr_data, 0);
    chk({tag, "_idle"}, serializer_idle, 1);
    chk({tag, "_gid"},  grant_id, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fifo_empty = '1;
    link_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pcyc[5];
    int pgnt[5];
    int npop;
    int acc;
    int mptr, exp_g, pend, beats;
    bit prev_dec, in_flit, load_now;
    logic [3:0]  prev_fe, exp_rd;
    logic [31:0] load_word;

    reset = 1'b0;
    fifo_empty = '1;
    link_ready = 1'b0;
    fifo_data = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    #1;
    rst_chk("por");

    // Single source 2, drained after its pop.
    tv[0]  = '{4'b1011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    tv[1]  = '{4'b1011, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0};
    tv[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hA0A0_0002};
    for (int i = 3; i <= 10; i++)
      tv[i] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0};
    tv[11] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tv[i].fe, tv[i].lr);
      chk($sformatf("vec%0d_rd", i),   read_fifo, tv[i].rd);
      chk($sformatf("vec%0d_ld", i),   sr_load, tv[i].ld);
      chk($sformatf("vec%0d_lv", i),   link_valid, tv[i].lv);
      chk($sformatf("vec%0d_sh", i),   sr_shift, tv[i].sh);
      chk($sformatf("vec%0d_idle", i), serializer_idle, tv[i].idle);
      chk($sformatf("vec%0d_gid", i),  grant_id, tv[i].gid);
      chk($sformatf("vec%0d_data", i), sr_data, tv[i].data);
    end

    // All sources busy: grants rotate 0,1,2,3,0 with a 10-cycle period.
    do_reset();
    npop = 0;
    for (int c = 0; c < 60; c++) begin
      step(4'b0000, 1'b1);
      if (read_fifo != 0 && npop < 5) begin
        pcyc[npop] = c;
        pgnt[npop] = grant_id;
        npop++;
      end
    end
    chk("rr_count", npop, 5);
    for (int k = 0; k < npop; k++) begin
      chk($sformatf("rr_grant%0d", k), pgnt[k], k % 4);
      chk($sformatf("rr_cycle%0d", k), pcyc[k], 1 + 10 * k);
    end

    // Stall at beat 3 for 5 cycles; flit still ends after 8 accepted beats.
    do_reset();
    step(4'b1110, 1'b1);
    step(4'b1110, 1'b1);
    step(4'b1111, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b1);
      chk("stall_pre_lv", link_valid, 1);
    end
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0);
      chk("stall_lv", link_valid, 1);
      chk("stall_sh", sr_shift, 0);
      chk("stall_gid", grant_id, 0);
    end
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 1'b1);
      if (!link_valid) break;
      acc++;
    end
    chk("stall_rest_beats", acc, 5);
    chk("stall_end_idle", serializer_idle, 1);

    // After grant 2, source 1 alone wins by wrapping; pointer then sits at 2.
    do_reset();
    step(4'b1011, 1'b1);
    step(4'b1011, 1'b1);
    for (int k = 0; k < 9; k++) step(4'b1101, 1'b1);
    step(4'b1101, 1'b1);
    chk("wrap_rd", read_fifo, 4'b0010);
    chk("wrap_gid", grant_id, 1);
    for (int k = 0; k < 9; k++) step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("wrap_next_rd", read_fifo, 4'b0100);
    chk("wrap_next_gid", grant_id, 2);

    // Abort: granted source 1 drains before POP.
    do_reset();
    step(4'b1101, 1'b1);
    step(4'b1111, 1'b1);
    chk("abort_rd", read_fifo, 0);
    chk("abort_gid", grant_id, 1);
    step(4'b0000, 1'b1);
    chk("abort_idle", serializer_idle, 1);
    chk("abort_ld", sr_load, 0);
    step(4'b0000, 1'b1);
    chk("abort_next_rd", read_fifo, 4'b0100);
    chk("abort_next_gid", grant_id, 2);

    // Reset at beat 5 discards the flit and restarts arbitration from 0.
    do_reset();
    step(4'b1110, 1'b1);
    step(4'b1110, 1'b1);
    step(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) step(4'b1111, 1'b1);
    chk("mid_lv_before", link_valid, 1);
    reset = 1'b0;
    fifo_empty = 4'b0000;
    #1;
    rst_chk("mid");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("mid_hold_rd", read_fifo, 0);
      chk("mid_hold_lv", link_valid, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    step(4'b0000, 1'b1);
    chk("mid_restart_rd", read_fifo, 4'b0001);
    chk("mid_restart_gid", grant_id, 0);

    // Randomized traffic against a source-queue / link-beat model.
    do_reset();
    mptr = 0; pend = -1; beats = 0;
    prev_dec = 1'b1; in_flit = 1'b0; prev_fe = 4'hF;
    load_word = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      load_now = 1'b0;
      if (pend >= 0) begin
        if (q[pend].size() > 0) load_word = q[pend].pop_front();
        fifo_data[pend*IW +: IW] = load_word;
        load_now = 1'b1;
        pend = -1;
      end
      for (int i = 0; i < NR; i++)
        if (q[i].size() < 4 && $urandom_range(7) == 0) q[i].push_back($urandom);
      for (int i = 0; i < NR; i++) fifo_empty[i] = (q[i].size() == 0);
      link_ready = ($urandom_range(3) != 0);
      #1;
      exp_rd = '0;
      exp_g = -1;
      if (prev_dec && prev_fe != 4'hF) begin
        for (int k = 0; k < NR; k++)
          if (exp_g < 0 && !prev_fe[(mptr + k) % NR]) exp_g = (mptr + k) % NR;
        exp_rd[exp_g] = 1'b1;
      end
      chk("rnd_rd", read_fifo, exp_rd);
      if (exp_g >= 0) begin
        chk("rnd_gid", grant_id, exp_g);
        mptr = (exp_g + 1) % NR;
        pend = exp_g;
      end
      chk("rnd_ld", sr_load, load_now);
      chk("rnd_data", sr_data, load_now ? load_word : 32'h0);
      chk("rnd_lv", link_valid, in_flit);
      chk("rnd_sh", sr_shift, in_flit && link_ready);
      chk("rnd_idle", serializer_idle, !in_flit && exp_g < 0 && !load_now);
      prev_dec = !in_flit && exp_g < 0 && !load_now;
      if (in_flit && link_ready) begin
        beats++;
        if (beats == BEATS) begin
          in_flit = 1'b0;
          prev_dec = 1'b1;
        end
      end
      if (load_now) begin
        in_flit = 1'b1;
        beats = 0;
      end
      prev_fe = fifo_empty;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
